// File: rtl/imm_gen_if.sv
// imm_gen_if: instruction-in / immediate-out bundle for the RV32I immediate
// generator.
//
// Signals:
//   Instruction   32  raw instruction word, driven by the decode stage
//   Extended_imm  32  registered, sign-extended immediate returned to it
//
// Modports:
//   master  decode-stage side: drives Instruction, observes Extended_imm
//   slave   imm_gen side: observes Instruction, drives Extended_imm
interface imm_gen_if;
  logic [31:0] Instruction;
  logic [31:0] Extended_imm;

  modport master (output Instruction, input Extended_imm);
  modport slave (input Instruction, output Extended_imm);
endinterface

// File: rtl/imm_gen.sv
// imm_gen: RV32I immediate generator.
//
// Identifies the encoding format of an instruction from its opcode, then
// extracts and sign-extends the immediate to 32 bits. The decoder is purely
// combinational and feeds one 32-bit output register, so an instruction
// sampled on edge N shows up on Extended_imm right after edge N.
//
// Ports:
//   clk   in   rising-edge clock
//   rstn  in   asynchronous, active-HIGH reset (the name is historical);
//              forces Extended_imm to zero while high
//   bus   slave modport of imm_gen_if (Instruction in, Extended_imm out)
//
// Parameters:
//   XLEN  output width; only 32 is supported
//
// Configuration macro:
//   IMMGEN_ZICSR_EN  when defined, SYSTEM instructions with Instruction[14]
//                    set (CSRRWI/CSRRSI/CSRRCI) return the zero-extended
//                    5-bit uimm from Instruction[19:15] instead of the
//                    I-type immediate.
module imm_gen #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rstn,
  imm_gen_if.slave   bus
);

  // Immediate encoding families the decoder can select.
  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_SHAMT,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_UIMM
  } fmt_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [31:0]     ins;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            sign;
  fmt_t            fmt;
  logic [XLEN-1:0] imm_next;

  assign ins    = bus.Instruction;
  assign opcode = ins[6:0];
  assign funct3 = ins[14:12];
  assign sign   = ins[31];

  // Opcode to format. OP-IMM shifts carry a shamt rather than a signed
  // immediate, so they are split off from the general I-type case. Anything
  // not listed (R-type, FENCE, illegal) yields a zero immediate.
  always_comb begin
    fmt = FMT_NONE;
    case (opcode)
      OP_LOAD, OP_JALR: fmt = FMT_I;
      OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) fmt = FMT_SHAMT;
        else                                      fmt = FMT_I;
      end
      OP_SYSTEM: begin
`ifdef IMMGEN_ZICSR_EN
        if (ins[14]) fmt = FMT_UIMM;
        else         fmt = FMT_I;
`else
        fmt = FMT_I;
`endif
      end
      OP_STORE:         fmt = FMT_S;
      OP_BRANCH:        fmt = FMT_B;
      OP_LUI, OP_AUIPC: fmt = FMT_U;
      OP_JAL:           fmt = FMT_J;
      default:          fmt = FMT_NONE;
    endcase
  end

  // Immediate assembly. Instruction[31] is the sign for every signed format;
  // B and J immediates are halfword offsets, hence the forced zero LSB.
  always_comb begin
    imm_next = '0;
    case (fmt)
      FMT_I:     imm_next = {{(XLEN-12){sign}}, ins[31:20]};
      FMT_SHAMT: imm_next = {{(XLEN-5){1'b0}}, ins[24:20]};
      FMT_S:     imm_next = {{(XLEN-12){sign}}, ins[31:25], ins[11:7]};
      FMT_B:     imm_next = {{(XLEN-13){sign}}, ins[31], ins[7], ins[30:25],
                             ins[11:8], 1'b0};
      FMT_U:     imm_next = {ins[31:12], 12'h000};
      FMT_J:     imm_next = {{(XLEN-21){sign}}, ins[31], ins[19:12], ins[20],
                             ins[30:21], 1'b0};
      FMT_UIMM:  imm_next = {{(XLEN-5){1'b0}}, ins[19:15]};
      default:   imm_next = '0;
    endcase
  end

  // Single output register; reset clears it without waiting for a clock
  // edge and discards whatever instruction was being decoded.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) bus.Extended_imm <= '0;
    else      bus.Extended_imm <= imm_next;
  end

endmodule

// File: tb/tb_imm_gen.sv
// tb_imm_gen: self-checking bench for imm_gen. Directed cases from the
// design's known instruction examples, then randomized instructions checked
// against an arithmetic reference model of the RV32I immediate rules.
// Honours IMMGEN_ZICSR_EN so the same bench covers both builds.
module tb_imm_gen;

  logic clk;
  logic rstn;
  int   nchecks;
  int   nerrors;

  imm_gen_if bus ();

  imm_gen #(.XLEN(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: rebuilds each immediate as a signed integer from its
  // field weights, then folds it back to 32 bits.
  function automatic logic [31:0] model(input logic [31:0] ins);
    int op;
    int f3;
    int v;
    op = int'(ins & 32'h7f);
    f3 = int'((ins >> 12) & 32'h7);
    v  = 0;
    case (op)
      'h03, 'h67: begin
        v = int'(ins >> 20);
        if (v >= 2048) v -= 4096;
      end
      'h13: begin
        if (f3 == 1 || f3 == 5) v = int'((ins >> 20) & 32'h1f);
        else begin
          v = int'(ins >> 20);
          if (v >= 2048) v -= 4096;
        end
      end
      'h73: begin
`ifdef IMMGEN_ZICSR_EN
        if (((ins >> 14) & 32'h1) == 32'h1) v = int'((ins >> 15) & 32'h1f);
        else begin
          v = int'(ins >> 20);
          if (v >= 2048) v -= 4096;
        end
`else
        v = int'(ins >> 20);
        if (v >= 2048) v -= 4096;
`endif
      end
      'h23: begin
        v = int'(ins >> 25) * 32 + int'((ins >> 7) & 32'h1f);
        if (v >= 2048) v -= 4096;
      end
      'h63: begin
        v = int'(ins >> 31) * 4096 + int'((ins >> 7) & 32'h1) * 2048 +
            int'((ins >> 25) & 32'h3f) * 32 + int'((ins >> 8) & 32'hf) * 2;
        if (v >= 4096) v -= 8192;
      end
      'h37, 'h17: return ins & 32'hFFFFF000;
      'h6f: begin
        v = int'(ins >> 31) * 1048576 + int'((ins >> 12) & 32'hff) * 4096 +
            int'((ins >> 20) & 32'h1) * 2048 + int'((ins >> 21) & 32'h3ff) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  // Present an instruction away from the edge and return just after the
  // capturing edge, where the registered result is stable.
  task automatic drive_and_wait(input logic [31:0] ins);
    @(negedge clk);
    bus.Instruction = ins;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    bus.Instruction = 32'hFFF00093;
    #1;
    nchecks++;
    if (bus.Extended_imm !== 32'h0) begin
      nerrors++;
      $display("[TB] FAIL reset_async: got %h expected %h", bus.Extended_imm, 32'h0);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      nchecks++;
      if (bus.Extended_imm !== 32'h0) begin
        nerrors++;
        $display("[TB] FAIL reset_hold: got %h expected %h", bus.Extended_imm, 32'h0);
      end
    end
    @(negedge clk);
    rstn = 1'b0;
  endtask

  task automatic test_itype();
    logic [31:0] ins [2] = '{32'h00000513, 32'hFFF00093};
    logic [31:0] exp [2] = '{32'h00000000, 32'hFFFFFFFF};
    for (int i = 0; i < 2; i++) begin
      drive_and_wait(ins[i]);
      nchecks++;
      if (bus.Extended_imm !== exp[i]) begin
        nerrors++;
        $display("[TB] FAIL itype_%0d: got %h expected %h", i, bus.Extended_imm, exp[i]);
      end
    end
  endtask

  // Consecutive edges, with a junk word flashed on the input between them
  // that must not reach the output.
  task automatic test_back_to_back();
    logic [31:0] ins [2] = '{32'h000B1823, 32'h0000A437};
    logic [31:0] exp [2] = '{32'h00000010, 32'h0000A000};
    for (int i = 0; i < 2; i++) begin
      drive_and_wait(ins[i]);
      nchecks++;
      if (bus.Extended_imm !== exp[i]) begin
        nerrors++;
        $display("[TB] FAIL b2b_%0d: got %h expected %h", i, bus.Extended_imm, exp[i]);
      end
      #1;
      bus.Instruction = 32'hFFF00093;
      #1;
      nchecks++;
      if (bus.Extended_imm !== exp[i]) begin
        nerrors++;
        $display("[TB] FAIL b2b_glitch_%0d: got %h expected %h", i, bus.Extended_imm, exp[i]);
      end
    end
  endtask

  task automatic test_btype_jtype();
    logic [31:0] ins [2] = '{32'hFE000EE3, 32'h0080006F};
    logic [31:0] exp [2] = '{32'hFFFFFFFC, 32'h00000008};
    for (int i = 0; i < 2; i++) begin
      drive_and_wait(ins[i]);
      nchecks++;
      if (bus.Extended_imm !== exp[i]) begin
        nerrors++;
        $display("[TB] FAIL bj_%0d: got %h expected %h", i, bus.Extended_imm, exp[i]);
      end
    end
  endtask

  task automatic test_shift_unused();
    logic [31:0] ins [3] = '{32'h40F0D093, 32'h00B50533, 32'h0FF0000F};
    logic [31:0] exp [3] = '{32'h0000000F, 32'h00000000, 32'h00000000};
    for (int i = 0; i < 3; i++) begin
      drive_and_wait(ins[i]);
      nchecks++;
      if (bus.Extended_imm !== exp[i]) begin
        nerrors++;
        $display("[TB] FAIL shift_unused_%0d: got %h expected %h", i, bus.Extended_imm, exp[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    drive_and_wait(32'hFFF00093);
    nchecks++;
    if (bus.Extended_imm !== 32'hFFFFFFFF) begin
      nerrors++;
      $display("[TB] FAIL arst_pre: got %h expected %h", bus.Extended_imm, 32'hFFFFFFFF);
    end
    #2;
    rstn = 1'b1;
    #1;
    nchecks++;
    if (bus.Extended_imm !== 32'h0) begin
      nerrors++;
      $display("[TB] FAIL arst_immediate: got %h expected %h", bus.Extended_imm, 32'h0);
    end
    for (int i = 0; i < 2; i++) begin
      drive_and_wait(32'h0080006F);
      nchecks++;
      if (bus.Extended_imm !== 32'h0) begin
        nerrors++;
        $display("[TB] FAIL arst_hold_%0d: got %h expected %h", i, bus.Extended_imm, 32'h0);
      end
    end
    @(negedge clk);
    rstn = 1'b0;
    bus.Instruction = 32'h0000A437;
    @(posedge clk);
    #1;
    nchecks++;
    if (bus.Extended_imm !== 32'h0000A000) begin
      nerrors++;
      $display("[TB] FAIL arst_release: got %h expected %h", bus.Extended_imm, 32'h0000A000);
    end
  endtask

  task automatic test_csr();
    logic [31:0] exp;
`ifdef IMMGEN_ZICSR_EN
    exp = 32'h00000003;
`else
    exp = 32'h00000340;
`endif
    drive_and_wait(32'h3401D0F3);
    nchecks++;
    if (bus.Extended_imm !== exp) begin
      nerrors++;
      $display("[TB] FAIL csr_imm: got %h expected %h", bus.Extended_imm, exp);
    end
    drive_and_wait(32'hFFF010F3);
    nchecks++;
    if (bus.Extended_imm !== 32'hFFFFFFFF) begin
      nerrors++;
      $display("[TB] FAIL csr_reg: got %h expected %h", bus.Extended_imm, 32'hFFFFFFFF);
    end
  endtask

  // Mostly legal opcodes with random fields, plus some fully random words.
  task automatic test_random();
    logic [6:0]  ops [12] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63,
                              7'h37, 7'h17, 7'h6f, 7'h33, 7'h0f, 7'h13};
    logic [31:0] ins;
    logic [31:0] exp;
    for (int i = 0; i < 300; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 7) != 0) ins[6:0] = ops[$urandom_range(0, 11)];
      exp = model(ins);
      drive_and_wait(ins);
      nchecks++;
      if (bus.Extended_imm !== exp) begin
        nerrors++;
        $display("[TB] FAIL random_%0d ins=%h: got %h expected %h", i, ins, bus.Extended_imm, exp);
      end
    end
  endtask

  initial begin
    nchecks = 0;
    nerrors = 0;
    bus.Instruction = 32'h0;
    test_reset();
    test_itype();
    test_back_to_back();
    test_btype_jtype();
    test_shift_unused();
    test_async_reset();
    test_csr();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
